// File: rtl/series_sum_engine.sv
// Sequential series accumulator: captures N and a series mode on start, adds one term per clock,
// then holds a saturating sum with done/ovf until the next accepted job.
module series_sum_engine #(
   parameter int N_W = 4,
   parameter int S_W = 12
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [1:0]     mode,
   input  logic [N_W-1:0] n,
   output logic           busy,
   output logic           done,
   output logic [S_W-1:0] s,
   output logic           ovf
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t         state, state_nxt;
   logic [N_W-1:0] n_lat;
   logic [1:0]     mode_lat;
   logic [N_W:0]   k;
   logic [S_W-1:0] acc;
   logic           ovf_r;
   logic           accept;
   logic           more;
   logic [S_W:0]   term;
   logic [S_W+1:0] sum;

   function automatic logic [S_W:0] term_of(input logic [1:0] m, input logic [N_W-1:0] kk);
      logic [S_W:0] kw;
      kw = (S_W+1)'(kk);
      case (m)
         2'b00:   return kw;
         2'b01:   return kw * kw;
         2'b10:   return (kw << 1) - 1'b1;
         default: return kw << 1;
      endcase
   endfunction

   // Clamp to all ones whenever the extended sum spills past S_W bits.
   function automatic logic [S_W-1:0] sat(input logic [S_W+1:0] v);
      return (v[S_W+1:S_W] != 2'b00) ? '1 : v[S_W-1:0];
   endfunction

   assign accept = (state != RUN) && start;
   assign more   = (k <= {1'b0, n_lat});
   assign term   = term_of(mode_lat, k[N_W-1:0]);
   assign sum    = (S_W+2)'(acc) + (S_W+2)'(term);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (!more) state_nxt = DONE;
         DONE:    if (start) state_nxt = RUN;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n_lat    <= '0;
         mode_lat <= '0;
         k        <= '0;
         acc      <= '0;
         ovf_r    <= 1'b0;
      end else if (accept) begin
         n_lat    <= n;
         mode_lat <= mode;
         k        <= (N_W+1)'(1);
         acc      <= '0;
         ovf_r    <= 1'b0;
      end else if (state == RUN && more) begin
         // Once saturated, sat() keeps acc at all ones for every later term.
         acc   <= sat(sum);
         ovf_r <= ovf_r | (sum[S_W+1:S_W] != 2'b00);
         k     <= k + 1'b1;
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);
   assign s    = acc;
   assign ovf  = ovf_r;

endmodule

// File: tb/tb_series_sum_engine.sv
// Bench for series_sum_engine: a 12-bit and an 8-bit result instance share stimulus and are
// checked every cycle against a job-level model, plus literal expectations for each scenario.
module tb_series_sum_engine;

   localparam int N_W = 4;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           start = 1'b0;
   logic [1:0]     mode = 2'b00;
   logic [N_W-1:0] n = '0;

   logic        busy_a, done_a, ovf_a;
   logic [11:0] s_a;
   logic        busy_b, done_b, ovf_b;
   logic [7:0]  s_b;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   series_sum_engine #(.N_W(N_W), .S_W(12)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .n(n),
      .busy(busy_a), .done(done_a), .s(s_a), .ovf(ovf_a));

   series_sum_engine #(.N_W(N_W), .S_W(8)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .n(n),
      .busy(busy_b), .done(done_b), .s(s_b), .ovf(ovf_b));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Unsaturated sum of the first j terms of series m.
   function automatic int psum(input int m, input int j);
      int acc;
      acc = 0;
      for (int kk = 1; kk <= j; kk++) begin
         case (m)
            0:       acc += kk;
            1:       acc += kk * kk;
            2:       acc += 2 * kk - 1;
            default: acc += 2 * kk;
         endcase
      end
      return acc;
   endfunction

   // Job-level model: cyc numbers the rising edges; a job started at edge c0 runs
   // through the state after edge c0+N and is done from edge c0+N+1 on.
   int cyc = 0;
   bit m_act = 1'b0;
   int m_c0 = 0, m_n = 0, m_mode = 0;

   always @(posedge clk) begin
      if (!rst_n) m_act = 1'b0;
      else if (start && !(m_act && (cyc - m_c0) <= m_n + 1)) begin
         m_act  = 1'b1;
         m_c0   = cyc;
         m_n    = int'(n);
         m_mode = int'(mode);
      end
      cyc = cyc + 1;
   end

   always @(negedge clk) begin
      int d, j, raw;
      bit eb, ed;
      if (!rst_n || !m_act) begin
         eb = 1'b0; ed = 1'b0; raw = 0;
      end else begin
         d   = (cyc - 1) - m_c0;
         eb  = (d <= m_n);
         ed  = (d > m_n);
         j   = (d < m_n) ? d : m_n;
         raw = psum(m_mode, j);
      end
      check("busy_a", 32'(busy_a), 32'(eb));
      check("done_a", 32'(done_a), 32'(ed));
      check("s_a", 32'(s_a), 32'((raw > 4095) ? 4095 : raw));
      check("busy_b", 32'(busy_b), 32'(eb));
      check("done_b", 32'(done_b), 32'(ed));
      check("s_b", 32'(s_b), 32'((raw > 255) ? 255 : raw));
      if (!rst_n || !m_act || ed) begin
         check("ovf_a", 32'(ovf_a), 32'(raw > 4095));
         check("ovf_b", 32'(ovf_b), 32'(raw > 255));
      end
   end

   task automatic start_job(input int nn, input int mm);
      @(posedge clk); #1;
      n = N_W'(nn);
      mode = 2'(mm);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, output int busy_cycles);
      int t;
      t = 0;
      busy_cycles = 0;
      while (!done_a && t < 40) begin
         if (busy_a) busy_cycles++;
         @(posedge clk); #1;
         t++;
      end
      check({name, "_timeout"}, 32'(done_a), 32'd1);
   endtask

   task automatic job(input string name, input int nn, input int mm,
                      input int sa, input int oa, input int sb, input int ob);
      int bc;
      start_job(nn, mm);
      wait_done(name, bc);
      check({name, "_s_a"}, 32'(s_a), 32'(sa));
      check({name, "_ovf_a"}, 32'(ovf_a), 32'(oa));
      check({name, "_s_b"}, 32'(s_b), 32'(sb));
      check({name, "_ovf_b"}, 32'(ovf_b), 32'(ob));
   endtask

   initial begin
      int bc;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("idle_s", 32'(s_a), 32'd0);
      check("idle_busy", 32'(busy_a), 32'd0);
      check("idle_done", 32'(done_a), 32'd0);

      start_job(9, 0);
      wait_done("n9m0", bc);
      check("n9m0_busy_len", 32'(bc), 32'd10);
      check("n9m0_s", 32'(s_a), 32'd45);
      check("n9m0_ovf", 32'(ovf_a), 32'd0);

      job("n9m1", 9, 1, 285, 0, 255, 1);
      job("n9m2", 9, 2, 81, 0, 81, 0);
      job("n9m3", 9, 3, 90, 0, 90, 0);
      job("n0m0", 0, 0, 0, 0, 0, 0);
      job("n15m1", 15, 1, 1240, 0, 255, 1);
      job("n15m0", 15, 0, 120, 0, 120, 0);
      job("n15m3", 15, 3, 240, 0, 240, 0);

      // Start during RUN must be ignored; latched n stays 9.
      start_job(9, 0);
      @(posedge clk); #1;
      n = 4'd3;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done("ignore", bc);
      check("ignore_s", 32'(s_a), 32'd45);

      // Back-to-back start from DONE.
      n = 4'd4;
      mode = 2'b00;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("b2b_done_drop", 32'(done_a), 32'd0);
      check("b2b_busy", 32'(busy_a), 32'd1);
      wait_done("b2b", bc);
      check("b2b_s", 32'(s_a), 32'd10);

      // Asynchronous reset mid-job.
      start_job(15, 1);
      repeat (4) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("arst_busy", 32'(busy_a), 32'd0);
      check("arst_s", 32'(s_a), 32'd0);
      check("arst_done", 32'(done_a), 32'd0);
      check("arst_ovf_b", 32'(ovf_b), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check("post_rst_busy", 32'(busy_a), 32'd0);
      check("post_rst_done", 32'(done_a), 32'd0);
      check("post_rst_s", 32'(s_a), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
